// File: rtl/max_pipe_pkg.sv
// max_pipe_pkg: shared defaults and FSM state type for the frame-maximum tracker.
package max_pipe_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;
endpackage

// File: rtl/max_tracker_if.sv
// max_tracker_if: sample stream in, frame maximum out.
interface max_tracker_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_LEN  = 16
);
  logic                         frame_start;
  logic                         abort;
  logic                         in_val;
  logic [DATA_WIDTH-1:0]        in_data;
  logic                         max_val;
  logic [DATA_WIDTH-1:0]        result;
  logic [$clog2(FRAME_LEN)-1:0] max_idx;
  logic                         busy;
  modport master (output frame_start, abort, in_val, in_data, input max_val, result, max_idx, busy);
  modport slave  (input frame_start, abort, in_val, in_data, output max_val, result, max_idx, busy);
endinterface

// File: rtl/max_cmp.sv
// max_cmp: strict-greater compare selecting the running max value and its index.
module max_cmp #(
  parameter int DW = 8,
  parameter int IW = 4
) (
  input  logic [DW-1:0] cur_max,
  input  logic [IW-1:0] cur_idx,
  input  logic [DW-1:0] sample,
  input  logic [IW-1:0] sample_idx,
  input  logic          first,
  output logic [DW-1:0] new_max,
  output logic [IW-1:0] new_idx
);
  logic sel;
  assign sel     = first || (sample > cur_max);
  assign new_max = sel ? sample : cur_max;
  assign new_idx = sel ? sample_idx : cur_idx;
endmodule

// File: rtl/max_tracker.sv
// max_tracker: per-frame maximum and its index, emitted as a one-cycle pulse.
module max_tracker
  import max_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FRAME_LEN  = 16
) (
  input logic         clk,
  input logic         rst_n,
  max_tracker_if.slave bus
);
  localparam int IW = $clog2(FRAME_LEN);
  localparam int CW = IW + 1;
  state_t                state, state_nx;
  logic [CW-1:0]         cnt, cnt_nx, s_cnt;
  logic [DATA_WIDTH-1:0] run_max, cmp_max, result_q;
  logic [IW-1:0]         run_idx, cmp_idx, idx_q;
  logic                  in_frame, restart, take, last;
  assign in_frame = state == ACCUM;
  // abort outranks frame_start; nothing is accepted while emitting
  assign restart  = bus.frame_start && !bus.abort && state != EMIT;
  assign take     = bus.in_val && (restart || (in_frame && !bus.abort));
  assign s_cnt    = restart ? '0 : cnt;
  assign last     = take && s_cnt == CW'(FRAME_LEN - 1);
  max_cmp #(.DW(DATA_WIDTH), .IW(IW)) u_cmp (
    .cur_max   (run_max),
    .cur_idx   (run_idx),
    .sample    (bus.in_data),
    .sample_idx(s_cnt[IW-1:0]),
    .first     (s_cnt == '0),
    .new_max   (cmp_max),
    .new_idx   (cmp_idx)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end
  always_comb begin
    state_nx = state == IDLE  ? (restart ? ACCUM : IDLE) :
               state == ACCUM ? (bus.abort ? IDLE : last ? EMIT : ACCUM) : IDLE;
    cnt_nx   = (in_frame && bus.abort) ? '0 : take ? s_cnt + CW'(1) : restart ? '0 : cnt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      run_max  <= '0;
      run_idx  <= '0;
      result_q <= '0;
      idx_q    <= '0;
    end else begin
      cnt <= cnt_nx;
      if (take) begin
        run_max <= cmp_max;
        run_idx <= cmp_idx;
      end
      if (last) begin
        result_q <= cmp_max;
        idx_q    <= cmp_idx;
      end
    end
  end
  always_comb begin
    bus.max_val = state == EMIT;
    bus.busy    = state != IDLE;
    bus.result  = result_q;
    bus.max_idx = idx_q;
  end
endmodule

// File: tb/tb_max_tracker.sv
// tb_max_tracker: directed and random frames against a queue-based reference model.
module tb_max_tracker;
  localparam int DW = 8;
  localparam int FL = 4;
  logic clk = 0;
  logic rst_n = 0;
  int checks = 0;
  int errors = 0;
  max_tracker_if #(.DATA_WIDTH(DW), .FRAME_LEN(FL)) bus ();
  max_tracker #(.DATA_WIDTH(DW), .FRAME_LEN(FL)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  bit m_active, m_emit;
  int m_q[$];
  int m_res, m_idx;
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".max_val"}, int'(bus.max_val), int'(m_emit));
    chk({tag, ".busy"}, int'(bus.busy), int'(m_active || m_emit));
    chk({tag, ".result"}, int'(bus.result), m_res);
    chk({tag, ".max_idx"}, int'(bus.max_idx), m_idx);
  endtask
  task automatic model(input bit fs, input bit ab, input bit v, input int d);
    if (m_emit) m_emit = 0;
    else if (m_active && ab) begin
      m_active = 0;
      m_q.delete();
    end else if (fs && !ab) begin
      m_active = 1;
      m_q.delete();
      if (v) m_q.push_back(d);
    end else if (m_active && v) m_q.push_back(d);
    if (m_q.size() == FL) begin
      m_res = m_q[0];
      m_idx = 0;
      foreach (m_q[i]) if (m_q[i] > m_res) begin
        m_res = m_q[i];
        m_idx = i;
      end
      m_emit = 1;
      m_active = 0;
      m_q.delete();
    end
  endtask
  task automatic step(input string tag, input bit fs, input bit ab, input bit v, input int d);
    @(negedge clk);
    bus.frame_start = fs;
    bus.abort = ab;
    bus.in_val = v;
    bus.in_data = DW'(d);
    model(fs, ab, v, d);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask
  task automatic frame(input string tag, input int a, input int b, input int c, input int e, input int gap);
    step(tag, 1, 0, 1, a);
    for (int k = 0; k < gap; k++) step(tag, 0, 0, 0, 0);
    step(tag, 0, 0, 1, b);
    for (int k = 0; k < gap; k++) step(tag, 0, 0, 0, 0);
    step(tag, 0, 0, 1, c);
    for (int k = 0; k < gap; k++) step(tag, 0, 0, 0, 0);
    step(tag, 0, 0, 1, e);
  endtask
  initial begin
    bus.frame_start = 0;
    bus.abort = 0;
    bus.in_val = 0;
    bus.in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1;
    step("idle_inval", 0, 0, 1, 77);
    frame("basic", 3, 9, 5, 7, 0);
    chk("basic.pulse", int'(bus.max_val), 1);
    chk("basic.res9", int'(bus.result), 9);
    chk("basic.idx1", int'(bus.max_idx), 1);
    step("emit_end", 1, 1, 1, 100);
    frame("tie", 6, 6, 2, 6, 0);
    chk("tie.idx0", int'(bus.max_idx), 0);
    step("gap", 0, 0, 0, 0);
    frame("zero", 0, 0, 0, 0, 0);
    chk("zero.pulse", int'(bus.max_val), 1);
    step("gap", 0, 0, 0, 0);
    step("restart", 1, 0, 1, 1);
    step("restart", 0, 0, 1, 2);
    frame("restart", 8, 4, 200, 3, 0);
    chk("restart.res200", int'(bus.result), 200);
    chk("restart.idx2", int'(bus.max_idx), 2);
    step("gap", 0, 0, 0, 0);
    step("abort", 1, 0, 1, 250);
    step("abort", 0, 0, 1, 251);
    step("abort", 0, 0, 1, 252);
    step("abort", 1, 1, 1, 253);
    chk("abort.busy0", int'(bus.busy), 0);
    chk("abort.keep", int'(bus.result), 200);
    step("abort_after", 0, 0, 1, 9);
    step("mid", 1, 0, 1, 50);
    step("mid", 0, 0, 1, 60);
    @(negedge clk);
    rst_n = 0;
    #1;
    m_active = 0;
    m_emit = 0;
    m_q.delete();
    m_res = 0;
    m_idx = 0;
    check_all("async_rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 4; k++) step("post_rst_idle", 0, 0, 1, 99);
    frame("gaps", 255, 0, 255, 254, 2);
    chk("gaps.res255", int'(bus.result), 255);
    chk("gaps.idx0", int'(bus.max_idx), 0);
    step("gaps.once", 0, 0, 0, 0);
    chk("gaps.single", int'(bus.max_val), 0);
    for (int k = 0; k < 400; k++) begin
      automatic int r = $urandom_range(0, 99);
      step("rand", r < 15, r >= 96, $urandom_range(0, 3) != 0, $urandom_range(0, 255));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/max_tracker.md
MAX_TRACKER -- requirements
Module: max_tracker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, sample and result width in bits.
REQ-002 SHALL have parameter FRAME_LEN, default 16, samples per frame; legal range 2..256.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port frame_start  input  1  one-cycle pulse that opens a new frame.
REQ-006 SHALL have port abort  input  1  discards the current frame without output.
REQ-007 SHALL have port in_val  input  1  in_data carries a sample this cycle.
REQ-008 SHALL have port in_data  input  DATA_WIDTH  unsigned sample.
REQ-009 SHALL have port max_val  output  1  one-cycle pulse: result holds a completed frame maximum; drives the downstream capture-enable.
REQ-010 SHALL have port result  output  DATA_WIDTH  frame maximum.
REQ-011 SHALL have port max_idx  output  clog2(FRAME_LEN)  index of the maximum within the frame.
REQ-012 SHALL have port busy  output  1  high in states ACCUM and EMIT.

Function
REQ-013 SHALL implement FSM states IDLE, ACCUM, EMIT; reset state IDLE.
REQ-014 IDLE: in_val ignored; frame_start -> ACCUM, sample counter cleared.
REQ-015 frame_start coincident with in_val SHALL accept that sample as index 0.
REQ-016 Index-0 sample SHALL load the running max and index unconditionally; no comparison against a cleared value.
REQ-017 Later samples SHALL replace the running max only if strictly greater (unsigned); ties keep the earliest index.
REQ-018 Sample counter SHALL increment by 1 per accepted sample; no gaps required between samples.
REQ-019 On acceptance of sample FRAME_LEN-1, FSM SHALL go to EMIT on the next edge.
REQ-020 EMIT SHALL last exactly one cycle with max_val=1 and result/max_idx equal to the frame maximum, then -> IDLE.
REQ-021 Latency SHALL be one cycle: max_val asserts in the cycle after the edge that accepted the last sample.
REQ-022 result and max_idx SHALL update only on entry to EMIT and hold until the next EMIT.
REQ-023 frame_start in ACCUM SHALL restart the frame: partial data discarded, counter cleared, coincident in_val taken as index 0.
REQ-024 abort in ACCUM SHALL return to IDLE with no max_val; result and max_idx unchanged.
REQ-025 abort and frame_start in the same cycle: abort SHALL take priority.
REQ-026 in_val, frame_start and abort in EMIT SHALL be ignored; the frame after EMIT requires a new frame_start from IDLE.
REQ-027 Counter SHALL be clog2(FRAME_LEN)+1 bits wide and SHALL NOT wrap within a frame.

Reset
REQ-028 On rst_n=0, asynchronously: state IDLE, counter 0, running max 0, max_val 0, result 0, max_idx 0, busy 0.
REQ-029 Reset mid-frame SHALL discard the frame; no max_val after release until a full new frame completes.
REQ-030 Inputs SHALL be ignored in the first edge after rst_n deasserts only while rst_n is still low; normal behaviour from the first edge with rst_n=1.

Structure
REQ-031 Package max_pipe_pkg SHALL hold the DATA_WIDTH default and the FSM state typedef (IDLE, ACCUM, EMIT).
REQ-032 One sub-module max_cmp (combinational strict-greater compare plus select of value and index) SHALL be instantiated once.

Verification (FRAME_LEN=4, DATA_WIDTH=8)
REQ-033 frame_start+in_val, samples 3,9,5,7 back-to-back -> max_val pulse one cycle after the 4th sample, result=9, max_idx=1.
REQ-034 Samples 6,6,2,6 -> result=6, max_idx=0 (tie keeps earliest); all-zero frame -> result=0, max_idx=0, max_val still pulses.
REQ-035 After samples 1,2, frame_start with 8, then 4,200,3 -> single max_val, result=200, max_idx=2; no pulse for the partial frame.
REQ-036 abort after 3 samples (abort and frame_start together) -> no max_val, busy=0 next cycle, result keeps previous value.
REQ-037 rst_n low for 2 cycles after 2 samples -> all outputs 0 immediately; in_val pulses in IDLE afterwards produce no max_val.
REQ-038 Samples 255,0,255,254 with idle gaps between samples -> result=255, max_idx=0; max_val high exactly one cycle.
